// File: rtl/pipe_haz_pkg.sv
// Shared types for the pipeline hazard controller: the per-slot instruction
// record, the bubble constant and the slot-count / select-width derivation.
package pipe_haz_pkg;

    // Slot records carry register addresses at this fixed width.
    // Narrower REG_AW values are zero-extended into it.
    localparam int SLOT_AW = 8;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] rd;
        logic               regwrite;
        logic               is_load;
        logic [SLOT_AW-1:0] rs1;
        logic [SLOT_AW-1:0] rs2;
        logic               use1;
        logic               use2;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // Tracker depth: ID/EX, EX/MEM, the extra MEM stages, then MEM/WB.
    function automatic int haz_depth(input int load_lat);
        return load_lat + 2;
    endfunction

    // Width of a forwarding select that can name slots 2..D as values 1..D-1.
    function automatic int haz_fwd_w(input int load_lat);
        return $clog2(load_lat + 2);
    endfunction

endpackage

// File: rtl/haz_slot_tracker.sv
// D-deep shift register of in-flight instruction records. Slot 1 takes
// the ID instruction or a bubble; every other slot advances each cycle.
module haz_slot_tracker
    import pipe_haz_pkg::*;
#(
    parameter int D = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            squash,
    input  slot_t           ins,
    output slot_t [D:1]     slots
);

    // Advance every slot; slot 1 takes the ID record only when it is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= D; k++) slots[k] <= SLOT_BUBBLE;
        end else begin
            for (int k = D; k >= 2; k--) slots[k] <= slots[k-1];
            slots[1] <= (push && !squash) ? ins : SLOT_BUBBLE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and EX operand
// forwarding selects. Optional perf counters behind macro HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_haz_pkg::*;
#(
    parameter  int LOAD_LAT = 1,
    parameter  int REG_AW   = 5,
    localparam int D        = haz_depth(LOAD_LAT),
    localparam int FWD_W    = haz_fwd_w(LOAD_LAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              redirect,
    output logic              stall,
    output logic              flush,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    slot_t         id_rec;
    slot_t [D:1]   slots;
    logic          load_use;
    logic          unused_slot_bits;

    // A slot can feed a value only if it really writes a non-zero register.
    function automatic logic is_producer(input slot_t s);
        return s.valid && s.regwrite && (s.rd != '0);
    endfunction

    // Pack the ID instruction into a slot record.
    always_comb begin
        id_rec          = SLOT_BUBBLE;
        id_rec.valid    = id_valid;
        id_rec.rd       = SLOT_AW'(id_rd);
        id_rec.regwrite = id_regwrite;
        id_rec.is_load  = id_is_load;
        id_rec.rs1      = SLOT_AW'(id_rs1);
        id_rec.rs2      = SLOT_AW'(id_rs2);
        id_rec.use1     = id_use1;
        id_rec.use2     = id_use2;
    end

    haz_slot_tracker #(.D(D)) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .push   (id_valid && !stall),
        .squash (redirect),
        .ins    (id_rec),
        .slots  (slots)
    );

    // Load-use: a load still short of MEM/WB cannot feed the ID instruction.
    always_comb begin
        load_use = 1'b0;
        for (int j = 1; j <= LOAD_LAT; j++) begin
            if (is_producer(slots[j]) && slots[j].is_load &&
                ((id_rec.use1 && id_rec.rs1 == slots[j].rd) ||
                 (id_rec.use2 && id_rec.rs2 == slots[j].rd)))
                load_use = 1'b1;
        end
    end

    // A redirect squashes the ID instruction, so it overrides any stall.
    assign stall = id_valid && load_use && !redirect;
    assign flush = redirect;

    // Forward selects: walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int j = D; j >= 2; j--) begin
            if (is_producer(slots[j]) && (!slots[j].is_load || j >= LOAD_LAT + 2)) begin
                if (slots[1].valid && slots[1].use1 && slots[1].rs1 == slots[j].rd)
                    fwd_a = FWD_W'(j - 1);
                if (slots[1].valid && slots[1].use2 && slots[1].rs2 == slots[j].rd)
                    fwd_b = FWD_W'(j - 1);
            end
        end
    end

    // Not every record field is consulted in every slot.
    assign unused_slot_bits = ^slots;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Saturating counts of stall and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            if (flush && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance per LOAD_LAT of 1 and 3 share the
// same ID stream; each is compared every cycle against an age-based model.
module tb_pipe_hazard_ctrl;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
        int rs1;
        bit u1;
        int rs2;
        bit u2;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ins_t cur;
    bit   redir_i;
    bit   rst_i;

    logic       id_valid, id_use1, id_use2, id_regwrite, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    assign id_valid    = cur.v;
    assign id_rd       = 5'(cur.rd);
    assign id_regwrite = cur.rw;
    assign id_is_load  = cur.ld;
    assign id_rs1      = 5'(cur.rs1);
    assign id_rs2      = 5'(cur.rs2);
    assign id_use1     = cur.u1;
    assign id_use2     = cur.u2;

    logic        st1, fl1, st3, fl3;
    logic [1:0]  fa1, fb1;
    logic [2:0]  fa3, fb3;
    logic [31:0] sc1, fc1, sc3, fc3;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .REG_AW(5)) u_dut1 (
        .clk(clk), .rst(rst_i), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .redirect(redir_i), .stall(st1), .flush(fl1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_ctrl #(.LOAD_LAT(3), .REG_AW(5)) u_dut3 (
        .clk(clk), .rst(rst_i), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .redirect(redir_i), .stall(st3), .flush(fl3),
        .fwd_a(fa3), .fwd_b(fb3), .stall_cnt(sc3), .flush_cnt(fc3));

    int nvec = 0;
    int nerr = 0;

    // Model: h[k][a] is the instruction that entered EX a cycles ago (slot a+1).
    ins_t   h [2][8];
    longint mst [2];
    longint mfl [2];

    logic       c_st1, c_st3, c_fl1;
    logic [2:0] c_fa1, c_fa3, c_fb1, c_fb3;
    logic [31:0] c_sc1, c_fc1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic ins_t mk(input bit v, input int rd, input bit rw, input bit ld,
                                input int rs1, input bit u1, input int rs2, input bit u2);
        ins_t r;
        r.v = v; r.rd = rd; r.rw = rw; r.ld = ld;
        r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        return r;
    endfunction

    function automatic bit writes(input ins_t p);
        return p.v && p.rw && p.rd != 0;
    endfunction

    function automatic bit exp_stall(input int k);
        ins_t p;
        if (!cur.v || redir_i) return 1'b0;
        for (int a = 0; a < lat_of(k); a++) begin
            p = h[k][a];
            if (writes(p) && p.ld &&
                ((cur.u1 && cur.rs1 == p.rd) || (cur.u2 && cur.rs2 == p.rd)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_fwd(input int k, input bit b);
        ins_t c, p;
        int   r;
        bit   u;
        c = h[k][0];
        r = b ? c.rs2 : c.rs1;
        u = b ? c.u2 : c.u1;
        if (!c.v || !u) return 0;
        // youngest first: the first hit is the answer
        for (int a = 1; a <= lat_of(k) + 1; a++) begin
            p = h[k][a];
            if (writes(p) && p.rd == r && (!p.ld || a == lat_of(k) + 1)) return a;
        end
        return 0;
    endfunction

    function automatic longint exp_cnt(input longint c);
`ifdef HAZ_PERF_CNT_EN
        return (c > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : c;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input ins_t i, input bit redir, input bit rstn, input bit do_chk);
        bit es [2];
        cur = i; redir_i = redir; rst_i = rstn;
        #1;
        for (int k = 0; k < 2; k++) es[k] = exp_stall(k);
        if (do_chk) begin
            chk("stall_l1", st1, es[0]);
            chk("stall_l3", st3, es[1]);
            chk("flush_l1", fl1, redir);
            chk("flush_l3", fl3, redir);
            chk("fwd_a_l1", fa1, exp_fwd(0, 0));
            chk("fwd_b_l1", fb1, exp_fwd(0, 1));
            chk("fwd_a_l3", fa3, exp_fwd(1, 0));
            chk("fwd_b_l3", fb3, exp_fwd(1, 1));
            chk("stall_cnt_l1", sc1, exp_cnt(mst[0]));
            chk("flush_cnt_l1", fc1, exp_cnt(mfl[0]));
            chk("stall_cnt_l3", sc3, exp_cnt(mst[1]));
            chk("flush_cnt_l3", fc3, exp_cnt(mfl[1]));
        end
        c_st1 = st1; c_st3 = st3; c_fl1 = fl1;
        c_fa1 = 3'(fa1); c_fb1 = 3'(fb1); c_fa3 = fa3; c_fb3 = fb3;
        c_sc1 = sc1; c_fc1 = fc1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                for (int a = 0; a < 8; a++) h[k][a].v = 1'b0;
                mst[k] = 0; mfl[k] = 0;
            end else begin
                for (int a = 7; a >= 1; a--) h[k][a] = h[k][a-1];
                h[k][0] = i;
                h[k][0].v = i.v && !es[k] && !redir;
                if (es[k]) mst[k]++;
                if (redir) mfl[k]++;
            end
        end
        #1;
    endtask

    ins_t NOP, LW5, ADD5;

    task automatic do_reset();
        step(NOP, 1'b0, 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1, 1'b1);
        chk("cnt_after_reset", {c_sc1, c_fc1}, 64'd0);
    endtask

    initial begin
        int n1, n3;
        ins_t r;
        NOP  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        LW5  = mk(1, 5, 1, 1, 0, 0, 0, 0);
        ADD5 = mk(1, 6, 1, 0, 5, 1, 1, 1);
        cur = NOP; redir_i = 1'b0; rst_i = 1'b0;
        step(NOP, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("reset_outputs", {c_st1, c_fl1, c_fa1, c_fb1, c_st3, c_fa3, c_fb3}, '0);

        // lw x5 then dependent add held in ID
        step(LW5, 1'b0, 1'b1, 1'b1);
        n1 = 0; n3 = 0;
        for (int s = 0; s < 5; s++) begin
            step(ADD5, 1'b0, 1'b1, 1'b1);
            n1 += int'(c_st1); n3 += int'(c_st3);
            if (s == 2) chk("loaduse_fwd_a_l1", c_fa1, 3'd2);
            if (s == 4) chk("loaduse_fwd_a_l3", c_fa3, 3'd4);
        end
        chk("loaduse_stall_cycles_l1", n1, 1);
        chk("loaduse_stall_cycles_l3", n3, 3);

        // one independent instruction between load and consumer
        do_reset();
        step(LW5, 1'b0, 1'b1, 1'b1);
        step(mk(1, 9, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        n1 = 0; n3 = 0;
        for (int s = 0; s < 4; s++) begin
            step(ADD5, 1'b0, 1'b1, 1'b1);
            n1 += int'(c_st1); n3 += int'(c_st3);
        end
        chk("gap_stall_cycles_l1", n1, 0);
        chk("gap_stall_cycles_l3", n3, 2);

        // two producers of x7: youngest wins; then an x0 producer
        do_reset();
        step(mk(1, 7, 1, 0, 1, 1, 2, 1), 1'b0, 1'b1, 1'b1);
        step(mk(1, 7, 1, 0, 3, 1, 4, 1), 1'b0, 1'b1, 1'b1);
        step(mk(1, 8, 1, 0, 0, 0, 7, 1), 1'b0, 1'b1, 1'b1);
        step(NOP, 1'b0, 1'b1, 1'b1);
        chk("youngest_fwd_b_l1", c_fb1, 3'd1);
        chk("youngest_fwd_b_l3", c_fb3, 3'd1);
        step(mk(1, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        step(mk(1, 8, 1, 0, 0, 0, 0, 1), 1'b0, 1'b1, 1'b1);
        step(NOP, 1'b0, 1'b1, 1'b1);
        chk("x0_fwd_b_l1", c_fb1, 3'd0);
        chk("x0_fwd_b_l3", c_fb3, 3'd0);

        // load-use hazard coinciding with redirect
        do_reset();
        step(LW5, 1'b0, 1'b1, 1'b1);
        step(ADD5, 1'b1, 1'b1, 1'b1);
        chk("redir_hazard_stall", {c_st1, c_st3}, 2'b00);
        chk("redir_hazard_flush", c_fl1, 1'b1);
        step(NOP, 1'b0, 1'b1, 1'b1);
        chk("redir_next_fwd", {c_fa1, c_fb1, c_fa3, c_fb3}, 12'd0);

        // reset in the middle of a 3-cycle stall
        do_reset();
        step(LW5, 1'b0, 1'b1, 1'b1);
        step(ADD5, 1'b0, 1'b1, 1'b1);
        step(ADD5, 1'b0, 1'b1, 1'b1);
        step(ADD5, 1'b0, 1'b0, 1'b1);
        step(ADD5, 1'b0, 1'b1, 1'b1);
        chk("reset_mid_stall", {c_st1, c_st3, c_fa3}, '0);

        // five stalls and two flushes on the LOAD_LAT=1 instance
        do_reset();
        for (int p = 0; p < 5; p++) begin
            step(LW5, 1'b0, 1'b1, 1'b1);
            step(ADD5, 1'b0, 1'b1, 1'b1);
            step(ADD5, 1'b0, 1'b1, 1'b1);
        end
        step(NOP, 1'b1, 1'b1, 1'b1);
        step(NOP, 1'b1, 1'b1, 1'b1);
        step(NOP, 1'b0, 1'b1, 1'b1);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_counts_l1", {c_sc1, c_fc1}, {32'd5, 32'd2});
`else
        chk("perf_counts_l1", {c_sc1, c_fc1}, 64'd0);
`endif

        // random traffic over a small register set to provoke hazards
        for (int s = 0; s < 400; s++) begin
            r = mk(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 2) == 0), $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                   $urandom_range(0, 3), bit'($urandom_range(0, 1)));
            step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL take parameter LOAD_LAT, default 1, meaning extra MEM stages before load data is forwardable (legal 1..3).
REQ-002 SHALL take parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL derive D = LOAD_LAT+2 tracker slots and FWD_W = clog2(D) select width.
REQ-004 clk  input  1  sole clock; one clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 id_valid  input  1  instruction present in ID.
REQ-007 id_rs1, id_rs2  input  REG_AW  ID source registers.
REQ-008 id_use1, id_use2  input  1  ID instruction reads rs1/rs2.
REQ-009 id_rd  input  REG_AW  ID destination register.
REQ-010 id_regwrite, id_is_load  input  1  ID writes rd; ID is a load.
REQ-011 redirect  input  1  taken branch/jump resolved this cycle.
REQ-012 stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-013 flush  output  1  squash IF/ID and ID/EX contents.
REQ-014 fwd_a, fwd_b  output  FWD_W  EX operand source: 0 = register file, k = slot k+1.
REQ-015 stall_cnt, flush_cnt  output  32  performance counters (see Configuration).

Function
REQ-016 Slot 1 = ID/EX; slot 2 = EX/MEM; slots 3..D-1 = MEM stages; slot D = MEM/WB.
- Each slot holds: valid, rd, regwrite, is_load, rs1, rs2, use1, use2.
REQ-017 Every cycle slots SHALL shift k -> k+1; slot D SHALL retire.
REQ-018 Slot 1 SHALL load ID fields when id_valid & !stall & !redirect; otherwise it SHALL load a bubble (valid=0).
REQ-019 A producer in slot j SHALL match only if valid, regwrite and rd != 0.
REQ-020 Forwarding: fwd_a SHALL select the youngest matching producer among slots 2..D against slot-1 rs1 when use1.
- Value = j-1; a load producer is eligible only when j >= LOAD_LAT+2.
- fwd_b identical for rs2.
REQ-021 fwd_a/fwd_b SHALL be 0 when slot 1 is invalid or no producer matches.
REQ-022 Load-use: stall SHALL assert combinationally when id_valid and id_use1/2 source equals rd of a matching load in slot j with j <= LOAD_LAT.
REQ-023 Stall duration SHALL therefore be LOAD_LAT+1-j cycles for a load in slot j, with no extra cycles.
REQ-024 flush SHALL equal redirect.
- When redirect and a hazard coincide, stall SHALL be 0 and flush SHALL win.
REQ-025 Redirect SHALL also clear slot 1 on the next edge.
- Slots 2..D SHALL be unaffected, because older instructions complete.
REQ-026 Back-to-back redirects SHALL each flush; there is no internal state machine beyond the slot shift register.

Reset
REQ-027 While rst=0 at a clock edge, all slot valid bits SHALL clear and stall_cnt/flush_cnt SHALL clear.
REQ-028 After reset, stall, flush, fwd_a and fwd_b SHALL all read 0 (given redirect=0).
- Reset mid-stall SHALL abandon the stall with no residual state.

Configuration
REQ-029 Macro HAZ_PERF_CNT_EN defined: stall_cnt SHALL increment per cycle with stall=1, and flush_cnt per cycle with flush=1.
- Both counters saturate at 32'hFFFFFFFF.
REQ-030 Macro HAZ_PERF_CNT_EN undefined: counter ports SHALL remain present and be tied to 0, with no counter flops.

Structure
REQ-031 Package pipe_haz_pkg SHALL hold the slot record typedef, the bubble constant and the FWD_W/D derivation function.
REQ-032 Sub-module haz_slot_tracker SHALL implement the D-slot shift register with bubble/squash insert.
- Matching logic and counters SHALL stay in pipe_hazard_ctrl.

Verification
REQ-033 LOAD_LAT=1: lw x5 then add x6,x5,x1 -> stall=1 for exactly 1 cycle, then fwd_a=2 (slot 3) when the add is in EX.
REQ-034 LOAD_LAT=3: lw x5 then dependent add -> stall for 3 cycles, then fwd_a=4.
- Repeat with one independent instruction between them -> stall 2 cycles.
REQ-035 add x7 in slot 2 and sub x7 in slot 3, consumer reads x7 -> fwd_b=1 (youngest wins).
- A rd=x0 producer -> fwd_b=0.
REQ-036 Load-use hazard and redirect in the same cycle -> stall=0, flush=1, slot 1 invalid next cycle, fwd_a=fwd_b=0.
REQ-037 rst=0 asserted during a 3-cycle stall -> the next cycle shows stall=0 and all slots invalid.
- With HAZ_PERF_CNT_EN: 5 stalls + 2 flushes -> stall_cnt=5, flush_cnt=2; counters read 0 after reset.
